// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core: datapath widths, opcodes and fetch states.
package cpu_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push and pop may coincide, even when full.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: readers only look at it while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: credit-limited in-order instruction fetch with redirect flush and stale-response drain.
module instr_fetch_unit #(
    parameter int unsigned PC_W      = cpu_pkg::PC_W,
    parameter int unsigned INSTR_W   = cpu_pkg::INSTR_W,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [3:0]         dec_op,
    output logic [PC_W-1:0]    dec_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);

    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e state, state_next;

    logic [PC_W-1:0]          pc, pc_next;
    logic [CNT_W-1:0]         outstanding, outstanding_next;
    logic [CNT_W-1:0]         stale, stale_next;
    logic [CNT_W:0]           in_use;
    logic [CNT_W:0]           redirect_stale;
    logic                     credit;
    logic                     accept;
    logic                     rsp_drop;
    logic                     rsp_take;
    logic                     pop_req;

    logic [INSTR_W+PC_W-1:0]  ibuf_head;
    logic                     ibuf_full, ibuf_empty;
    logic [CNT_W-1:0]         ibuf_count;
    logic [PC_W-1:0]          tag_head;
    logic                     tag_full, tag_empty;
    logic [CNT_W-1:0]         tag_count;

    assign accept   = imem_req && imem_ready;
    assign rsp_drop = imem_rvalid && (stale != '0);
    assign rsp_take = imem_rvalid && (stale == '0) && (outstanding != '0);
    assign pop_req  = dec_valid && dec_ready;

    // The slot being popped this cycle is already counted as free, which sustains one fetch per cycle.
    assign in_use = (CNT_W+1)'(ibuf_count) + (CNT_W+1)'(outstanding) - (CNT_W+1)'(pop_req);
    assign credit = (in_use < (CNT_W+1)'(BUF_DEPTH));

    assign redirect_stale = (CNT_W+1)'(stale) + (CNT_W+1)'(outstanding) + (CNT_W+1)'(accept)
                          - (CNT_W+1)'(rsp_drop || rsp_take);

    always_comb begin
        pc_next          = pc;
        outstanding_next = outstanding;
        stale_next       = stale;
        if (redirect) begin
            pc_next          = redirect_pc;
            outstanding_next = '0;
            stale_next       = CNT_W'(redirect_stale);
        end else begin
            if (accept) pc_next = pc + 1'b1;
            outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(rsp_take);
            if (rsp_drop) stale_next = stale - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            pc          <= pc_next;
            outstanding <= outstanding_next;
            stale       <= stale_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FS_RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FS_RUN:   if (redirect && stale_next != '0) state_next = FS_DRAIN;
            FS_DRAIN: if (stale_next == '0)             state_next = FS_RUN;
            default:  state_next = FS_RUN;
        endcase
    end

    always_comb begin
        imem_req  = !reset && (state == FS_RUN) && credit;
        imem_addr = pc;
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (PC_W)
    ) u_tagq (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (accept),
        .push_data (pc),
        .pop       (rsp_take),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (INSTR_W + PC_W)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (rsp_take),
        .push_data ({imem_rdata, tag_head}),
        .pop       (pop_req),
        .pop_data  (ibuf_head),
        .full      (ibuf_full),
        .empty     (ibuf_empty),
        .count     (ibuf_count)
    );

    assign dec_valid = !ibuf_empty;
    assign dec_instr = dec_valid ? ibuf_head[PC_W +: INSTR_W]     : '0;
    assign dec_op    = dec_valid ? ibuf_head[PC_W+INSTR_W-1 -: 4] : '0;
    assign dec_pc    = dec_valid ? ibuf_head[PC_W-1:0]            : '0;

    a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (outstanding != '0 || stale != '0));
    a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (reset)
        tag_count == outstanding);
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
        accept |-> !tag_full);
    a_tag_present: assert property (@(posedge clk) disable iff (reset)
        rsp_take |-> !tag_empty);
    a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (reset)
        rsp_take |-> (!ibuf_full || pop_req));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order 1-cycle memory model and a decode-side log.
module tb_instr_fetch_unit;

    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [3:0]  dec_op;
    logic [15:0] dec_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic        mem_stall = 1'b0;
    logic [15:0] mem_xor   = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [3:0]  op;
        int          cyc;
    } dec_rec_t;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } acc_rec_t;

    dec_rec_t dlog[$];
    acc_rec_t alog[$];

    instr_fetch_unit #(
        .PC_W      (16),
        .INSTR_W   (16),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_op      (dec_op),
        .dec_pc      (dec_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Decode / request monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!reset && dec_valid && dec_ready) dlog.push_back('{dec_pc, dec_instr, dec_op, cyc});
        if (!reset && imem_req && imem_ready) alog.push_back('{imem_addr, cyc});
    end

    // Memory: in-order, data = addr ^ mem_xor, answers the cycle after acceptance unless stalled.
    initial begin
        logic [15:0] q[$];
        logic        acc;
        logic [15:0] acc_addr;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            acc      = !reset && imem_req && imem_ready;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            if (acc) q.push_back(acc_addr);
            if (reset) q.delete();
            if (q.size() > 0 && !mem_stall) begin
                imem_rvalid = 1'b1;
                imem_rdata  = q.pop_front() ^ mem_xor;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        dec_ready   = 1'b0;
        mem_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        dlog.delete();
        alog.delete();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        dec_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (imem_req !== 1'b0)    begin fails++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
        tests++; if (imem_addr !== 16'h0)  begin fails++; $display("FAIL rst_addr: got %h, expected 0000", imem_addr); end
        tests++; if (dec_valid !== 1'b0)   begin fails++; $display("FAIL rst_valid: got %b, expected 0", dec_valid); end
        tests++; if (dec_instr !== 16'h0)  begin fails++; $display("FAIL rst_instr: got %h, expected 0000", dec_instr); end
        tests++; if (dec_op !== 4'h0)      begin fails++; $display("FAIL rst_op: got %h, expected 0", dec_op); end
        tests++; if (dec_pc !== 16'h0)     begin fails++; $display("FAIL rst_pc: got %h, expected 0000", dec_pc); end
    endtask

    task automatic test_free_run();
        apply_reset();
        dec_ready = 1'b1;
        run(8);
        @(negedge clk);
        tests++;
        if (dlog.size() < 4 || alog.size() < 1) begin
            fails++; $display("FAIL fr_count: got %0d deliveries, expected at least 4", dlog.size());
        end else begin
            tests++; if (alog[0].addr !== 16'h0) begin fails++; $display("FAIL fr_first_addr: got %h, expected 0000", alog[0].addr); end
            tests++; if (dlog[0].cyc - alog[0].cyc != 2) begin
                fails++; $display("FAIL fr_latency: got %0d cycles, expected 2", dlog[0].cyc - alog[0].cyc);
            end
            for (int i = 0; i < 4; i++) begin
                tests++; if (dlog[i].pc !== 16'(i) || dlog[i].instr !== 16'(i)) begin
                    fails++; $display("FAIL fr_seq[%0d]: got pc %h instr %h, expected %h", i, dlog[i].pc, dlog[i].instr, 16'(i));
                end
                tests++; if (dlog[i].cyc != dlog[0].cyc + i) begin
                    fails++; $display("FAIL fr_back_to_back[%0d]: got cycle %0d, expected %0d", i, dlog[i].cyc, dlog[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        dec_ready = 1'b0;
        run(8);
        @(negedge clk);
        tests++; if (alog.size() != 2) begin fails++; $display("FAIL bp_req_count: got %0d, expected 2", alog.size()); end
        else begin
            tests++; if (alog[0].addr !== 16'h0 || alog[1].addr !== 16'h1) begin
                fails++; $display("FAIL bp_req_addr: got %h %h, expected 0000 0001", alog[0].addr, alog[1].addr);
            end
        end
        tests++; if (imem_req !== 1'b0)   begin fails++; $display("FAIL bp_req_idle: got %b, expected 0", imem_req); end
        tests++; if (dec_valid !== 1'b1)  begin fails++; $display("FAIL bp_valid: got %b, expected 1", dec_valid); end
        run(3);
        @(negedge clk);
        tests++; if (dec_instr !== 16'h0 || dec_pc !== 16'h0) begin
            fails++; $display("FAIL bp_hold: got instr %h pc %h, expected 0000 0000", dec_instr, dec_pc);
        end
        step();
        dec_ready = 1'b1;
        run(10);
        @(negedge clk);
        tests++;
        if (dlog.size() < 3) begin
            fails++; $display("FAIL bp_release_count: got %0d, expected at least 3", dlog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (dlog[i].pc !== 16'(i) || dlog[i].instr !== 16'(i)) begin
                    fails++; $display("FAIL bp_order[%0d]: got pc %h instr %h, expected %h", i, dlog[i].pc, dlog[i].instr, 16'(i));
                end
            end
        end
    endtask

    task automatic test_redirect_drain();
        int hits;
        apply_reset();
        dec_ready   = 1'b1;
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0004;
        step();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        mem_stall  = 1'b1;
        run(4);
        @(negedge clk);
        tests++; if (alog.size() != 2) begin fails++; $display("FAIL rd_issued: got %0d, expected 2", alog.size()); end
        else begin
            tests++; if (alog[0].addr !== 16'h4 || alog[1].addr !== 16'h5) begin
                fails++; $display("FAIL rd_issued_addr: got %h %h, expected 0004 0005", alog[0].addr, alog[1].addr);
            end
        end
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        @(negedge clk);
        tests++; if (dut.state !== FS_DRAIN) begin fails++; $display("FAIL rd_state: got %0d, expected DRAIN", dut.state); end
        tests++; if (dut.stale !== 2)        begin fails++; $display("FAIL rd_stale: got %0d, expected 2", dut.stale); end
        tests++; if (imem_req !== 1'b0)      begin fails++; $display("FAIL rd_req_drain: got %b, expected 0", imem_req); end
        tests++; if (dec_valid !== 1'b0)     begin fails++; $display("FAIL rd_flushed: got %b, expected 0", dec_valid); end
        step();
        mem_stall = 1'b0;
        dlog.delete();
        run(8);
        @(negedge clk);
        hits = 0;
        foreach (dlog[i]) if (dlog[i].pc == 16'h4 || dlog[i].pc == 16'h5) hits++;
        tests++; if (hits != 0) begin fails++; $display("FAIL rd_dropped: got %0d stale deliveries, expected 0", hits); end
        tests++; if (dlog.size() < 1 || dlog[0].pc !== 16'h0040 || dlog[0].instr !== 16'h0040) begin
            fails++; $display("FAIL rd_target: got %0d entries, first pc %h, expected pc 0040 data 0040",
                              dlog.size(), (dlog.size() > 0) ? dlog[0].pc : 16'hxxxx);
        end
        tests++; if (dut.state !== FS_RUN) begin fails++; $display("FAIL rd_back_to_run: got %0d, expected RUN", dut.state); end
    endtask

    task automatic test_redirect_same_cycle();
        int hits;
        apply_reset();
        dec_ready   = 1'b1;
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0007;
        step();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        @(negedge clk);
        tests++; if (imem_rvalid !== 1'b1 || imem_rdata !== 16'h7) begin
            fails++; $display("FAIL sc_rvalid7: got rvalid %b data %h, expected 1 0007", imem_rvalid, imem_rdata);
        end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h8) begin
            fails++; $display("FAIL sc_accept8: got req %b addr %h, expected 1 0008", imem_req, imem_addr);
        end
        step();
        redirect = 1'b0;
        @(negedge clk);
        tests++; if (dut.stale !== 1) begin fails++; $display("FAIL sc_stale: got %0d, expected 1", dut.stale); end
        run(8);
        @(negedge clk);
        hits = 0;
        foreach (dlog[i]) if (dlog[i].pc == 16'h7 || dlog[i].pc == 16'h8) hits++;
        tests++; if (hits != 0) begin fails++; $display("FAIL sc_dropped: got %0d stale deliveries, expected 0", hits); end
        tests++; if (dlog.size() < 1 || dlog[0].pc !== 16'h0010 || dlog[0].instr !== 16'h0010) begin
            fails++; $display("FAIL sc_target: got %0d entries, first pc %h, expected pc 0010",
                              dlog.size(), (dlog.size() > 0) ? dlog[0].pc : 16'hxxxx);
        end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] exp_pc [4];
        exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        apply_reset();
        dec_ready   = 1'b1;
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        run(8);
        @(negedge clk);
        tests++;
        if (dlog.size() < 4) begin
            fails++; $display("FAIL wrap_count: got %0d, expected at least 4", dlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (dlog[i].pc !== exp_pc[i] || dlog[i].instr !== exp_pc[i]) begin
                    fails++; $display("FAIL wrap_seq[%0d]: got pc %h instr %h, expected %h", i, dlog[i].pc, dlog[i].instr, exp_pc[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        mem_xor = 16'h5000;
        apply_reset();
        dec_ready = 1'b1;
        run(6);
        @(negedge clk);
        tests++; if (dec_valid !== 1'b1 || dut.outstanding !== 1) begin
            fails++; $display("FAIL mr_pre: got valid %b outstanding %0d, expected 1 1", dec_valid, dut.outstanding);
        end
        #1;
        reset = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 16'h0) begin
            fails++; $display("FAIL mr_imem_zero: got req %b addr %h, expected 0 0000", imem_req, imem_addr);
        end
        tests++; if (dec_valid !== 1'b0 || dec_instr !== 16'h0 || dec_op !== 4'h0 || dec_pc !== 16'h0) begin
            fails++; $display("FAIL mr_dec_zero: got valid %b instr %h op %h pc %h, expected all 0", dec_valid, dec_instr, dec_op, dec_pc);
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        dlog.delete();
        alog.delete();
        run(6);
        @(negedge clk);
        tests++; if (alog.size() < 1 || alog[0].addr !== 16'h0) begin
            fails++; $display("FAIL mr_restart_addr: got %0d requests, expected first addr 0000", alog.size());
        end
        tests++; if (dlog.size() < 1 || dlog[0].pc !== 16'h0 || dlog[0].instr !== 16'h5000 || dlog[0].op !== 4'h5) begin
            fails++; $display("FAIL mr_restart_dec: got %0d entries, first op %h, expected pc 0000 instr 5000 op 5",
                              dlog.size(), (dlog.size() > 0) ? dlog[0].op : 4'hx);
        end
        mem_xor = 16'h0000;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b0;
        dec_ready   = 1'b0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_pc_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
